// File: rtl/key_debounce_sync.sv
// Push-button front end: two-flop synchroniser, bidirectional debounce FSM,
// and registered press / release / long-press event outputs (key is active-low).
module key_debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned LONG_CYCLES     = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_held
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             key_out_q, key_out_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             held_q, held_d;

  // Long-press counter step: saturating increment and the one-time fire condition.
  logic [CNT_W-1:0] lcnt_inc_c;
  logic             long_fire_c;

  always_comb begin
    lcnt_inc_c  = (lcnt_q < LONG_MAX) ? (lcnt_q + CNT_ONE) : lcnt_q;
    long_fire_c = (lcnt_q == LONG_LAST);
  end

  // Next-state, counters and registered-output values.
  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    lcnt_d    = lcnt_q;
    key_out_d = key_out_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    held_d    = held_q;

    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = CNT_ONE;
        end else begin
          dcnt_d  = CNT_ZERO;
        end
      end

      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = IDLE;
          dcnt_d  = CNT_ZERO;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = PRESSED;
          key_out_d = 1'b0;
          press_d   = 1'b1;
          dcnt_d    = CNT_ZERO;
          lcnt_d    = CNT_ZERO;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        lcnt_d = lcnt_inc_c;
        if (long_fire_c) begin
          long_d = 1'b1;
          held_d = 1'b1;
        end
        if (sync2_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = CNT_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (sync2_q && (dcnt_q == DB_LAST)) begin
          // An accepted release takes priority over a long-press due on this edge.
          state_d   = IDLE;
          key_out_d = 1'b1;
          release_d = 1'b1;
          held_d    = 1'b0;
          lcnt_d    = CNT_ZERO;
          dcnt_d    = CNT_ZERO;
        end else begin
          lcnt_d = lcnt_inc_c;
          if (long_fire_c) begin
            long_d = 1'b1;
            held_d = 1'b1;
          end
          if (!sync2_q) begin
            state_d = PRESSED;
            dcnt_d  = CNT_ZERO;
          end else begin
            dcnt_d = dcnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        dcnt_d  = CNT_ZERO;
      end
    endcase
  end

  // All state, including the synchroniser, resets asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dcnt_q    <= CNT_ZERO;
      lcnt_q    <= CNT_ZERO;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      key_out_q <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      lcnt_q    <= lcnt_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      key_out_q <= key_out_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign key_out       = key_out_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign long_held     = held_q;

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_key_debounce_sync;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic key_raw = 1'b1;
  logic key_out, press_pulse, release_pulse, long_pulse, long_held;

  key_debounce_sync #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_raw      (key_raw),
    .key_out      (key_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .long_held    (long_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int   press_cnt = 0, release_cnt = 0, long_cnt = 0, both_cnt = 0, lo_cnt = 0;
  int   press_cyc = 0, release_cyc = 0, long_cyc = 0;
  logic held_prev = 1'b0, rel_held_now = 1'b0, rel_held_prev = 1'b0, held_at_long = 1'b0;

  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin press_cnt++; press_cyc = cyc; end
    if (release_pulse === 1'b1) begin
      release_cnt++; release_cyc = cyc;
      rel_held_now = long_held; rel_held_prev = held_prev;
    end
    if (long_pulse === 1'b1) begin long_cnt++; long_cyc = cyc; held_at_long = long_held; end
    if (press_pulse === 1'b1 && release_pulse === 1'b1) both_cnt++;
    if (key_out === 1'b0) lo_cnt++;
    held_prev = long_held;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold key low for h cycles then release and let everything settle.
  task automatic press_hold(input int h);
    key_raw = 1'b0;
    wait_cyc(h);
    key_raw = 1'b1;
    wait_cyc(25);
  endtask

  int c, p0, r0, l0, lo0;
  int holds [3] = '{19, 20, 21};
  int longs [3] = '{0, 0, 1};

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_key_out", int'(key_out), 1);
    chk("rst_pulses", int'({press_pulse, release_pulse, long_pulse, long_held}), 0);
    wait_cyc(3);
    rst_n = 1'b1;

    // 1: idle with key released
    wait_cyc(50);
    chk("idle_key_out", int'(key_out), 1);
    chk("idle_events", press_cnt + release_cnt + long_cnt + lo_cnt, 0);

    // 2: clean short press, latency both ways
    c = cyc; p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
    key_raw = 1'b0;
    wait_cyc(5);
    chk("press_lat_pre_ko", int'(key_out), 1);
    chk("press_lat_pre_pp", int'(press_pulse), 0);
    wait_cyc(1);
    chk("press_lat_ko", int'(key_out), 0);
    chk("press_lat_pp", int'(press_pulse), 1);
    wait_cyc(1);
    chk("press_pp_width", int'(press_pulse), 0);
    chk("press_ko_hold", int'(key_out), 0);
    wait_cyc(3);
    key_raw = 1'b1;
    wait_cyc(5);
    chk("rel_lat_pre_rp", int'(release_pulse), 0);
    chk("rel_lat_pre_ko", int'(key_out), 0);
    wait_cyc(1);
    chk("rel_lat_rp", int'(release_pulse), 1);
    chk("rel_lat_ko", int'(key_out), 1);
    wait_cyc(10);
    chk("short_press_cnt", press_cnt - p0, 1);
    chk("short_rel_cnt", release_cnt - r0, 1);
    chk("short_long_cnt", long_cnt - l0, 0);
    chk("short_press_at", press_cyc - c, 6);

    // 3: bounce never reaching four stable samples
    p0 = press_cnt; lo0 = lo_cnt;
    key_raw = 1'b0; wait_cyc(3);
    key_raw = 1'b1; wait_cyc(1);
    key_raw = 1'b0; wait_cyc(3);
    key_raw = 1'b1; wait_cyc(10);
    chk("bounce_press_cnt", press_cnt - p0, 0);
    chk("bounce_key_low", lo_cnt - lo0, 0);

    // 4: two-cycle release glitch mid-press, long count not restarted
    p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
    key_raw = 1'b0; wait_cyc(8);
    key_raw = 1'b1; wait_cyc(2);
    key_raw = 1'b0; wait_cyc(3);
    chk("glitch_key_out", int'(key_out), 0);
    wait_cyc(27);
    chk("glitch_no_release", release_cnt - r0, 0);
    chk("glitch_long_cnt", long_cnt - l0, 1);
    chk("glitch_long_delay", long_cyc - press_cyc, 20);
    key_raw = 1'b1; wait_cyc(20);
    chk("glitch_rel_cnt", release_cnt - r0, 1);
    chk("glitch_rel_delay", release_cyc - press_cyc, 40);

    // 5: 40-cycle hold, long fires once and long_held spans to release
    l0 = long_cnt;
    press_hold(40);
    chk("hold40_long_cnt", long_cnt - l0, 1);
    chk("hold40_long_delay", long_cyc - press_cyc, 20);
    chk("hold40_held_at_long", int'(held_at_long), 1);
    chk("hold40_held_before_rel", int'(rel_held_prev), 1);
    chk("hold40_held_at_rel", int'(rel_held_now), 0);
    chk("hold40_held_after", int'(long_held), 0);

    // Long-press boundary: 19 and 20 (release wins) give none, 21 fires
    for (int i = 0; i < 3; i++) begin
      l0 = long_cnt;
      press_hold(holds[i]);
      chk($sformatf("hold%0d_long_cnt", holds[i]), long_cnt - l0, longs[i]);
      chk($sformatf("hold%0d_duration", holds[i]), release_cyc - press_cyc, holds[i]);
    end

    // 6: reset while long_held
    p0 = press_cnt; r0 = release_cnt;
    key_raw = 1'b0; wait_cyc(40);
    chk("pre_rst_held", int'(long_held), 1);
    chk("pre_rst_key_out", int'(key_out), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_out", int'(key_out), 1);
    chk("mid_rst_outputs", int'({press_pulse, release_pulse, long_pulse, long_held}), 0);
    key_raw = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(30);
    chk("post_rst_no_release", release_cnt - r0, 0);
    chk("post_rst_press_cnt", press_cnt - p0, 1);
    chk("post_rst_key_out", int'(key_out), 1);

    chk("press_release_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
